// File: rtl/axi_pkg.sv
// Shared encodings for the AXI4 memory responder: burst/resp codes, FSM states and
// the address-phase attribute check.
package axi_pkg;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrResp,
        StRdReq,
        StRdCap,
        StRdData
    } fsm_state_e;

    // True when the address-phase attributes cannot be served by this responder.
    function automatic logic attr_err(input logic [2:0] size, input logic [7:0] len,
                                      input logic [1:0] burst, input logic [2:0] max_size);
        logic bad_wrap;
        bad_wrap = (burst == BurstWrap) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        return (size > max_size) || (burst == 2'b11) || bad_wrap;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [2:0]           size,
    input  logic [7:0]           len,
    input  logic [1:0]           burst,
    output logic [AddrWidth-1:0] next_addr
);

    logic [AddrWidth-1:0] inc;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] incr_addr;

    always_comb begin
        inc       = AddrWidth'(1) << size;
        wrap_mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
        incr_addr = addr + inc;
        case (burst)
            BurstIncr: next_addr = incr_addr;
            BurstWrap: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:   next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 subordinate serving one read or write burst at a time against a synchronous
// SRAM-style port with 1-cycle read latency.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        axi_aw_valid_i,
    output logic                        axi_aw_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
    input  logic [7:0]                  axi_aw_len_i,
    input  logic [2:0]                  axi_aw_size_i,
    input  logic [1:0]                  axi_aw_burst_i,

    input  logic                        axi_w_valid_i,
    output logic                        axi_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
    input  logic                        axi_w_last_i,

    output logic                        axi_b_valid_o,
    input  logic                        axi_b_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
    output logic [1:0]                  axi_b_resp_o,

    input  logic                        axi_ar_valid_i,
    output logic                        axi_ar_ready_o,
    input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
    input  logic [7:0]                  axi_ar_len_i,
    input  logic [2:0]                  axi_ar_size_i,
    input  logic [1:0]                  axi_ar_burst_i,

    output logic                        axi_r_valid_o,
    input  logic                        axi_r_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     axi_r_id_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o,
    output logic [1:0]                  axi_r_resp_o,
    output logic                        axi_r_last_o,

    output logic                        mem_cen_o,
    output logic                        mem_wen_o,
    output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] mem_wmask_o,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  MaxSize   = 3'($clog2(StrbWidth));

    fsm_state_e                state_q, state_d;
    logic                      prio_q, prio_d;  // 0: write wins contention, 1: read wins
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [2:0]                size_q, size_d;
    logic [1:0]                burst_q, burst_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [AXI_ADDR_WIDTH-1:0] next_addr;
    logic                      last_beat;
    logic                      last_err;

    assign last_beat = (cnt_q == len_q);

    axi_burst_addr #(
        .AddrWidth (AXI_ADDR_WIDTH)
    ) u_burst_addr (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        last_err       = 1'b0;
        axi_aw_ready_o = 1'b0;
        axi_ar_ready_o = 1'b0;
        axi_w_ready_o  = 1'b0;
        axi_b_valid_o  = 1'b0;
        axi_b_resp_o   = RespOkay;
        axi_b_id_o     = id_q;
        axi_r_valid_o  = 1'b0;
        axi_r_resp_o   = RespOkay;
        axi_r_last_o   = 1'b0;
        axi_r_id_o     = id_q;
        axi_r_data_o   = rdata_q;
        mem_cen_o      = 1'b0;
        mem_wen_o      = 1'b0;
        mem_addr_o     = addr_q;
        mem_wdata_o    = axi_w_data_i;
        mem_wmask_o    = axi_w_strb_i;

        case (state_q)
            StIdle: begin
                axi_aw_ready_o = axi_aw_valid_i & (~axi_ar_valid_i | ~prio_q);
                axi_ar_ready_o = axi_ar_valid_i & (~axi_aw_valid_i | prio_q);
                if (axi_aw_valid_i && axi_ar_valid_i) begin
                    prio_d = ~prio_q;
                end
                if (axi_aw_ready_o) begin
                    id_d    = axi_aw_id_i;
                    addr_d  = axi_aw_addr_i;
                    len_d   = axi_aw_len_i;
                    size_d  = axi_aw_size_i;
                    burst_d = axi_aw_burst_i;
                    cnt_d   = 8'd0;
                    err_d   = attr_err(axi_aw_size_i, axi_aw_len_i, axi_aw_burst_i, MaxSize);
                    state_d = StWrData;
                end else if (axi_ar_ready_o) begin
                    id_d    = axi_ar_id_i;
                    addr_d  = axi_ar_addr_i;
                    len_d   = axi_ar_len_i;
                    size_d  = axi_ar_size_i;
                    burst_d = axi_ar_burst_i;
                    cnt_d   = 8'd0;
                    err_d   = attr_err(axi_ar_size_i, axi_ar_len_i, axi_ar_burst_i, MaxSize);
                    state_d = StRdReq;
                end
            end
            StWrData: begin
                axi_w_ready_o = 1'b1;
                if (axi_w_valid_i) begin
                    // A mislabelled last beat poisons the burst and is itself not written.
                    last_err  = (axi_w_last_i != last_beat);
                    mem_cen_o = ~err_q & ~last_err;
                    mem_wen_o = ~err_q & ~last_err;
                    err_d     = err_q | last_err;
                    addr_d    = next_addr;
                    cnt_d     = cnt_q + 8'd1;
                    if (last_beat) begin
                        state_d = StWrResp;
                    end
                end
            end
            StWrResp: begin
                axi_b_valid_o = 1'b1;
                axi_b_resp_o  = err_q ? RespSlverr : RespOkay;
                if (axi_b_ready_i) begin
                    state_d = StIdle;
                end
            end
            StRdReq: begin
                mem_cen_o = ~err_q;
                state_d   = StRdCap;
            end
            StRdCap: begin
                rdata_d = err_q ? '0 : mem_rdata_i;
                state_d = StRdData;
            end
            StRdData: begin
                axi_r_valid_o = 1'b1;
                axi_r_last_o  = last_beat;
                axi_r_resp_o  = err_q ? RespSlverr : RespOkay;
                if (axi_r_ready_i) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        addr_d  = next_addr;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StRdReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem with a pattern-returning memory model and access logs.
module tb_axi_slave_mem;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_valid = 0, aw_ready;
    logic [3:0]  aw_id = 0;
    logic [63:0] aw_addr = 0;
    logic [7:0]  aw_len = 0;
    logic [2:0]  aw_size = 0;
    logic [1:0]  aw_burst = 0;
    logic        w_valid = 0, w_ready, w_last = 0;
    logic [63:0] w_data = 0;
    logic [7:0]  w_strb = 0;
    logic        b_valid, b_ready = 0;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid = 0, ar_ready;
    logic [3:0]  ar_id = 0;
    logic [63:0] ar_addr = 0;
    logic [7:0]  ar_len = 0;
    logic [2:0]  ar_size = 0;
    logic [1:0]  ar_burst = 0;
    logic        r_valid, r_ready = 0, r_last;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        mem_cen, mem_wen;
    logic [63:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic [7:0]  mem_wmask;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } wr_ent_t;
    wr_ent_t     wr_log[$];
    logic [63:0] rd_log[$];

    always #5 clk = ~clk;

    axi_slave_mem dut (
        .clk            (clk),
        .rst            (rst),
        .axi_aw_valid_i (aw_valid),
        .axi_aw_ready_o (aw_ready),
        .axi_aw_id_i    (aw_id),
        .axi_aw_addr_i  (aw_addr),
        .axi_aw_len_i   (aw_len),
        .axi_aw_size_i  (aw_size),
        .axi_aw_burst_i (aw_burst),
        .axi_w_valid_i  (w_valid),
        .axi_w_ready_o  (w_ready),
        .axi_w_data_i   (w_data),
        .axi_w_strb_i   (w_strb),
        .axi_w_last_i   (w_last),
        .axi_b_valid_o  (b_valid),
        .axi_b_ready_i  (b_ready),
        .axi_b_id_o     (b_id),
        .axi_b_resp_o   (b_resp),
        .axi_ar_valid_i (ar_valid),
        .axi_ar_ready_o (ar_ready),
        .axi_ar_id_i    (ar_id),
        .axi_ar_addr_i  (ar_addr),
        .axi_ar_len_i   (ar_len),
        .axi_ar_size_i  (ar_size),
        .axi_ar_burst_i (ar_burst),
        .axi_r_valid_o  (r_valid),
        .axi_r_ready_i  (r_ready),
        .axi_r_id_o     (r_id),
        .axi_r_data_o   (r_data),
        .axi_r_resp_o   (r_resp),
        .axi_r_last_o   (r_last),
        .mem_cen_o      (mem_cen),
        .mem_wen_o      (mem_wen),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_wmask_o    (mem_wmask),
        .mem_rdata_i    (mem_rdata)
    );

    function automatic logic [63:0] pat(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0]};
    endfunction

    // Memory model: reads return an address-derived pattern one cycle after the request.
    always @(posedge clk) begin
        if (!rst && mem_cen) begin
            if (mem_wen) wr_log.push_back('{addr: mem_addr, data: mem_wdata, mask: mem_wmask});
            else begin
                rd_log.push_back(mem_addr);
                mem_rdata <= pat(mem_addr);
            end
        end
    end

    // Drivers: all enter and leave 1ns after a rising edge.
    task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit ok);
        ok = 0;
        aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        for (int i = 0; i < 20; i++) begin
            #1; if (aw_ready) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        aw_valid = 0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit ok);
        ok = 0;
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
        for (int i = 0; i < 20; i++) begin
            #1; if (ar_ready) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        ar_valid = 0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                          output bit ok);
        ok = 0;
        w_valid = 1; w_data = data; w_strb = strb; w_last = last;
        for (int i = 0; i < 20; i++) begin
            #1; if (w_ready) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        w_valid = 0; w_last = 0;
    endtask

    task automatic recv_b(output logic [3:0] id, output logic [1:0] resp, output bit ok);
        ok = 0; id = 'x; resp = 'x;
        b_ready = 1;
        for (int i = 0; i < 20; i++) begin
            #1; if (b_valid) begin ok = 1; id = b_id; resp = b_resp; end
            @(posedge clk); #1;
            if (ok) break;
        end
        b_ready = 0;
    endtask

    // wait_cyc: cycles spent with r_valid low before the handshake.
    task automatic recv_r(output logic [63:0] data, output logic [3:0] id, output logic [1:0] resp,
                          output logic last, output int wait_cyc, output bit ok);
        ok = 0; data = 'x; id = 'x; resp = 'x; last = 'x; wait_cyc = -1;
        r_ready = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (r_valid) begin
                ok = 1; data = r_data; id = r_id; resp = r_resp; last = r_last; wait_cyc = i;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        r_ready = 0;
    endtask

    task automatic test_reset;
        logic [9:0] outs;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        outs = {aw_ready, ar_ready, w_ready, b_valid, r_valid, mem_cen, mem_wen, r_last,
                |b_resp, |r_resp};
        checks++;
        if (outs !== 10'd0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0", outs);
        end
        checks++;
        if (dut.state_q !== StIdle) begin
            failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, StIdle);
        end
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write;
        bit ok; logic [3:0] id; logic [1:0] resp;
        wr_log.delete();
        send_aw(4'h5, 64'h100, 8'd0, 3'd3, BurstIncr, ok);
        #1;
        checks++;
        if (!ok || w_ready !== 1'b1) begin
            failures++; $display("FAIL wr_wready ok=%0d w_ready=%b exp=1", ok, w_ready);
        end
        send_w(64'h1122334455667788, 8'hFF, 1'b1, ok);
        #1;
        checks++;
        if (!ok || b_valid !== 1'b1) begin
            failures++; $display("FAIL wr_bvalid_timing ok=%0d b_valid=%b exp=1", ok, b_valid);
        end
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== '{64'h100, 64'h1122334455667788, 8'hFF}) begin
            failures++;
            $display("FAIL wr_mem_access n=%0d got=%h exp=%h", wr_log.size(),
                     wr_log.size() ? wr_log[0] : '0, {64'h100, 64'h1122334455667788, 8'hFF});
        end
        recv_b(id, resp, ok);
        checks++;
        if (!ok || id !== 4'h5 || resp !== RespOkay) begin
            failures++; $display("FAIL wr_bresp ok=%0d id=%h resp=%b exp id=5 resp=00", ok, id, resp);
        end
    endtask

    task automatic test_incr_read;
        bit ok; logic [63:0] d; logic [3:0] id; logic [1:0] resp; logic last; int wc;
        logic [63:0] exp_addr[4];
        exp_addr = '{64'h200, 64'h208, 64'h210, 64'h218};
        rd_log.delete();
        send_ar(4'h3, 64'h200, 8'd3, 3'd3, BurstIncr, ok);
        #1;
        checks++;
        if (!ok || mem_cen !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 64'h200) begin
            failures++;
            $display("FAIL rd_req_timing ok=%0d cen=%b wen=%b addr=%h exp 1/0/200",
                     ok, mem_cen, mem_wen, mem_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++; $display("FAIL rd_rvalid_early got=%b exp=0", r_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (r_valid !== 1'b1) begin
            failures++; $display("FAIL rd_rvalid_t3 got=%b exp=1", r_valid);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (r_valid !== 1'b1 || r_data !== pat(64'h200) || r_last !== 1'b0) begin
                failures++;
                $display("FAIL rd_stall_hold cyc=%0d valid=%b data=%h last=%b exp 1/%h/0",
                         c, r_valid, r_data, r_last, pat(64'h200));
            end
            @(posedge clk); #1;
        end
        for (int b = 0; b < 4; b++) begin
            recv_r(d, id, resp, last, wc, ok);
            checks++;
            if (!ok || d !== pat(exp_addr[b]) || id !== 4'h3 || resp !== RespOkay
                || last !== (b == 3)) begin
                failures++;
                $display("FAIL rd_incr_beat%0d data=%h id=%h resp=%b last=%b exp %h/3/00/%0d",
                         b, d, id, resp, last, pat(exp_addr[b]), b == 3);
            end
            if (b > 0) begin
                checks++;
                if (wc != 2) begin
                    failures++; $display("FAIL rd_beat_gap beat=%0d wait=%0d exp=2", b, wc);
                end
            end
        end
        checks++;
        if (rd_log.size() != 4 || rd_log[0] !== exp_addr[0] || rd_log[1] !== exp_addr[1]
            || rd_log[2] !== exp_addr[2] || rd_log[3] !== exp_addr[3]) begin
            failures++; $display("FAIL rd_incr_addrs n=%0d exp 200,208,210,218", rd_log.size());
        end
    endtask

    task automatic test_wrap_read;
        bit ok; logic [63:0] d; logic [3:0] id; logic [1:0] resp; logic last; int wc;
        logic [63:0] exp_addr[4];
        exp_addr = '{64'h118, 64'h100, 64'h108, 64'h110};
        rd_log.delete();
        send_ar(4'h9, 64'h118, 8'd3, 3'd3, BurstWrap, ok);
        for (int b = 0; b < 4; b++) begin
            recv_r(d, id, resp, last, wc, ok);
            checks++;
            if (!ok || d !== pat(exp_addr[b]) || resp !== RespOkay || last !== (b == 3)) begin
                failures++;
                $display("FAIL rd_wrap_beat%0d data=%h resp=%b last=%b exp %h/00/%0d",
                         b, d, resp, last, pat(exp_addr[b]), b == 3);
            end
        end
        checks++;
        if (rd_log.size() != 4 || rd_log[0] !== exp_addr[0] || rd_log[1] !== exp_addr[1]
            || rd_log[2] !== exp_addr[2] || rd_log[3] !== exp_addr[3]) begin
            failures++; $display("FAIL rd_wrap_addrs n=%0d exp 118,100,108,110", rd_log.size());
        end
    endtask

    task automatic test_contention;
        bit ok; logic [63:0] d; logic [3:0] id; logic [1:0] resp; logic last; int wc;
        aw_valid = 1; aw_id = 4'h1; aw_addr = 64'h180; aw_len = 0; aw_size = 3;
        aw_burst = BurstIncr;
        ar_valid = 1; ar_id = 4'h2; ar_addr = 64'h100; ar_len = 0; ar_size = 3;
        ar_burst = BurstIncr;
        #1;
        checks++;
        if (aw_ready !== 1'b1 || ar_ready !== 1'b0) begin
            failures++; $display("FAIL cont_first aw_ready=%b ar_ready=%b exp 1/0", aw_ready, ar_ready);
        end
        @(posedge clk); #1;
        aw_valid = 0;
        send_w(64'hCAFE, 8'h0F, 1'b1, ok);
        recv_b(id, resp, ok);
        checks++;
        if (!ok || id !== 4'h1 || resp !== RespOkay) begin
            failures++; $display("FAIL cont_bresp id=%h resp=%b exp 1/00", id, resp);
        end
        aw_valid = 1;
        #1;
        checks++;
        if (ar_ready !== 1'b1 || aw_ready !== 1'b0) begin
            failures++; $display("FAIL cont_second aw_ready=%b ar_ready=%b exp 0/1", aw_ready, ar_ready);
        end
        @(posedge clk); #1;
        aw_valid = 0; ar_valid = 0;
        recv_r(d, id, resp, last, wc, ok);
        checks++;
        if (!ok || d !== pat(64'h100) || id !== 4'h2 || last !== 1'b1) begin
            failures++; $display("FAIL cont_read data=%h id=%h last=%b exp %h/2/1", d, id, last,
                                 pat(64'h100));
        end
    endtask

    task automatic test_errors;
        bit ok; logic [63:0] d; logic [3:0] id; logic [1:0] resp; logic last; int wc;
        wr_log.delete(); rd_log.delete();
        send_aw(4'h2, 64'h300, 8'd0, 3'd4, BurstIncr, ok);
        send_w(64'h55, 8'hFF, 1'b1, ok);
        recv_b(id, resp, ok);
        checks++;
        if (!ok || id !== 4'h2 || resp !== RespSlverr) begin
            failures++; $display("FAIL err_size_bresp id=%h resp=%b exp 2/10", id, resp);
        end
        checks++;
        if (wr_log.size() != 0 || rd_log.size() != 0) begin
            failures++; $display("FAIL err_size_mem n=%0d exp=0", wr_log.size() + rd_log.size());
        end
        send_aw(4'h6, 64'h400, 8'd2, 3'd3, BurstIncr, ok);
        send_w(64'h1, 8'hFF, 1'b0, ok);
        send_w(64'h2, 8'hFF, 1'b1, ok);
        #1;
        checks++;
        if (w_ready !== 1'b1 || b_valid !== 1'b0) begin
            failures++; $display("FAIL err_wlast_early w_ready=%b b_valid=%b exp 1/0", w_ready, b_valid);
        end
        send_w(64'h3, 8'hFF, 1'b1, ok);
        recv_b(id, resp, ok);
        checks++;
        if (!ok || id !== 4'h6 || resp !== RespSlverr) begin
            failures++; $display("FAIL err_wlast_bresp id=%h resp=%b exp 6/10", id, resp);
        end
        rd_log.delete();
        send_ar(4'hA, 64'h500, 8'd2, 3'd3, BurstWrap, ok);
        for (int b = 0; b < 3; b++) begin
            recv_r(d, id, resp, last, wc, ok);
            checks++;
            if (!ok || d !== 64'd0 || resp !== RespSlverr || last !== (b == 2)) begin
                failures++; $display("FAIL err_rd_beat%0d data=%h resp=%b last=%b exp 0/10/%0d",
                                     b, d, resp, last, b == 2);
            end
        end
        checks++;
        if (rd_log.size() != 0) begin
            failures++; $display("FAIL err_rd_mem n=%0d exp=0", rd_log.size());
        end
    endtask

    task automatic test_reset_mid_burst;
        bit ok; logic [63:0] d; logic [3:0] id; logic [1:0] resp; logic last; int wc;
        logic [3:0] outs;
        send_ar(4'h4, 64'h600, 8'd3, 3'd3, BurstIncr, ok);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (r_valid !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pre r_valid=%b exp=1", r_valid);
        end
        rst = 1;
        @(posedge clk); #1;
        outs = {r_valid, b_valid, mem_cen, w_ready};
        checks++;
        if (outs !== 4'd0 || dut.state_q !== StIdle) begin
            failures++; $display("FAIL rst_mid_outs got=%b state=%0d exp 0/%0d", outs, dut.state_q,
                                 StIdle);
        end
        rst = 0;
        @(posedge clk); #1;
        rd_log.delete();
        send_ar(4'h8, 64'h700, 8'd1, 3'd3, BurstIncr, ok);
        for (int b = 0; b < 2; b++) begin
            recv_r(d, id, resp, last, wc, ok);
            checks++;
            if (!ok || d !== pat(64'h700 + 64'(b * 8)) || id !== 4'h8 || last !== (b == 1)) begin
                failures++; $display("FAIL rst_after_beat%0d data=%h id=%h last=%b", b, d, id, last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr_read();
        test_wrap_read();
        test_contention();
        test_errors();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
